// File: rtl/sampling_pkg.sv
// +--------------------------------------------------------------+
// | sampling_pkg: shared tile geometry and output FSM states      |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

package sampling_pkg;

   localparam int TILE_SRC_DIM = 4;
   localparam int TILE_DST_DIM = 8;
   localparam int SRC_PIXELS   = TILE_SRC_DIM * TILE_SRC_DIM;
   localparam int DST_PIXELS   = TILE_DST_DIM * TILE_DST_DIM;

   typedef enum logic [1:0] {
      OUT_IDLE   = 2'd0,
      OUT_EMIT   = 2'd1,
      OUT_FINISH = 2'd2
   } out_state_t;

endpackage

`default_nettype wire

// File: rtl/upsample_pixel_sel.sv
// +--------------------------------------------------------------+
// | upsample_pixel_sel: 8x8 position -> pixel from a 4x4 source   |
// | Optional: UPSAMPLE_BILINEAR_EN (2x2 averaging). Rev 1.0       |
// +--------------------------------------------------------------+
`default_nettype none

module upsample_pixel_sel
   import sampling_pkg::*;
#(
   parameter int PIXEL_W = 16
)
(
   input  logic [PIXEL_W-1:0] src [SRC_PIXELS],
   input  logic [5:0]         pos,
   output logic [PIXEL_W-1:0] pixel
);

   // pos = {r[2:0], c[2:0]}; source row/col are r>>1 and c>>1
   logic [1:0] sr;
   logic [1:0] sc;

   assign sr = pos[5:4];
   assign sc = pos[2:1];

`ifdef UPSAMPLE_BILINEAR_EN
   logic [1:0]         sr2;
   logic [1:0]         sc2;
   logic [PIXEL_W+1:0] sum;

   // Odd output positions blend with the next source sample, clamped at the edge
   assign sc2 = (pos[0] && (sc != 2'd3)) ? sc + 2'd1 : sc;
   assign sr2 = (pos[3] && (sr != 2'd3)) ? sr + 2'd1 : sr;

   assign sum = {2'b00, src[{sr,  sc }]} + {2'b00, src[{sr,  sc2}]}
              + {2'b00, src[{sr2, sc }]} + {2'b00, src[{sr2, sc2}]};

   assign pixel = sum[PIXEL_W+1:2];
`else
   logic unused_odd_bits;

   assign unused_odd_bits = pos[3] ^ pos[0];
   assign pixel           = src[{sr, sc}];
`endif

endmodule

`default_nettype wire

// File: rtl/upsampling_module_2x.sv
// +--------------------------------------------------------------+
// | upsampling_module_2x: double-buffered 4x4 -> 8x8 tile scaler  |
// | Optional: UPSAMPLE_BILINEAR_EN (see upsample_pixel_sel). Rev 1.0 |
// +--------------------------------------------------------------+
`default_nettype none

module upsampling_module_2x
   import sampling_pkg::*;
#(
   parameter int PIXEL_W = 16,
   parameter int WATCH_W = 16
)
(
   input  logic               Clock,
   input  logic               Input_Reset_n,
   input  logic [PIXEL_W-1:0] Input_Pixel,
   input  logic               Input_Valid,
   output logic               Input_Ready,
   input  logic               Input_Finish,
   output logic [PIXEL_W-1:0] Output_Pixel,
   output logic               Output_Valid,
   input  logic               Output_Ready,
   output logic               Output_Finish,
   output logic [WATCH_W-1:0] Watch
);

   logic [PIXEL_W-1:0] input_buffer [SRC_PIXELS];
   logic [PIXEL_W-1:0] latch_buffer [SRC_PIXELS];
   logic [3:0]         input_counter;
   logic               input_filled;
   logic [5:0]         output_counter;
   out_state_t         state;
   logic               accept;

   assign Input_Ready = !input_filled;
   assign accept      = Input_Valid && Input_Ready && !Input_Finish;

   always_ff @(posedge Clock or negedge Input_Reset_n) begin
      if (!Input_Reset_n) begin
         input_counter <= '0;
         input_filled  <= 1'b0;
         for (int i = 0; i < SRC_PIXELS; i++) input_buffer[i] <= '0;
      end else begin
         // The output side empties the full buffer; accept is impossible then
         if ((state == OUT_IDLE) && input_filled) input_filled <= 1'b0;

         if (Input_Finish && !input_filled) begin
            input_counter <= '0;
         end else if (accept) begin
            input_buffer[input_counter] <= Input_Pixel;
            input_counter               <= input_counter + 4'd1;
            if (input_counter == 4'(SRC_PIXELS - 1)) input_filled <= 1'b1;
         end
      end
   end

   always_ff @(posedge Clock or negedge Input_Reset_n) begin
      if (!Input_Reset_n) begin
         state          <= OUT_IDLE;
         output_counter <= '0;
         Output_Valid   <= 1'b0;
         Output_Finish  <= 1'b0;
         Watch          <= '0;
         for (int i = 0; i < SRC_PIXELS; i++) latch_buffer[i] <= '0;
      end else begin
         case (state)
            OUT_IDLE: begin
               if (input_filled) begin
                  latch_buffer   <= input_buffer;
                  output_counter <= '0;
                  Output_Valid   <= 1'b1;
                  state          <= OUT_EMIT;
               end
            end
            OUT_EMIT: begin
               if (Output_Ready) begin
                  output_counter <= output_counter + 6'd1;
                  if (output_counter == 6'(DST_PIXELS - 1)) begin
                     Output_Valid  <= 1'b0;
                     Output_Finish <= 1'b1;
                     state         <= OUT_FINISH;
                  end
               end
            end
            OUT_FINISH: begin
               Output_Finish <= 1'b0;
               Watch         <= Watch + WATCH_W'(1);
               state         <= OUT_IDLE;
            end
            default: begin
               Output_Valid  <= 1'b0;
               Output_Finish <= 1'b0;
               state         <= OUT_IDLE;
            end
         endcase
      end
   end

   upsample_pixel_sel #(
      .PIXEL_W (PIXEL_W)
   ) u_pixel_sel (
      .src   (latch_buffer),
      .pos   (output_counter),
      .pixel (Output_Pixel)
   );

endmodule

`default_nettype wire

// File: tb/tb_upsampling_module_2x.sv
// Self-checking bench for upsampling_module_2x: tile model plus literal pins.
// Expected values follow UPSAMPLE_BILINEAR_EN when it is defined.
`default_nettype none

module tb_upsampling_module_2x;

   logic        Clock = 1'b0;
   logic        Input_Reset_n = 1'b0;
   logic [15:0] Input_Pixel = '0;
   logic        Input_Valid = 1'b0;
   logic        Input_Ready;
   logic        Input_Finish = 1'b0;
   logic [15:0] Output_Pixel;
   logic        Output_Valid;
   logic        Output_Ready;
   logic        Output_Finish;
   logic [15:0] Watch;

   int          checks = 0;
   int          passed = 0;
   logic [15:0] src_tile [16];
   logic [15:0] exp_q [$];
   logic [15:0] got [$];
   int          pix_idx = 0;
   int          hs_total = 0;
   int          finish_count = 0;
   logic        held_valid = 1'b0;
   logic [15:0] held_pix = '0;
   logic        bp_mode = 1'b0;

`ifdef UPSAMPLE_BILINEAR_EN
   int lit_row0 [8] = '{0, 8, 16, 24, 32, 40, 48, 48};
   int lit_row1 [8] = '{32, 40, 48, 56, 64, 72, 80, 80};
   int lit_row7 [8] = '{192, 200, 208, 216, 224, 232, 240, 240};
`else
   int lit_row0 [8] = '{0, 0, 16, 16, 32, 32, 48, 48};
   int lit_row1 [8] = '{0, 0, 16, 16, 32, 32, 48, 48};
   int lit_row7 [8] = '{192, 192, 208, 208, 224, 224, 240, 240};
`endif

   upsampling_module_2x #(
      .PIXEL_W (16),
      .WATCH_W (16)
   ) dut (
      .Clock         (Clock),
      .Input_Reset_n (Input_Reset_n),
      .Input_Pixel   (Input_Pixel),
      .Input_Valid   (Input_Valid),
      .Input_Ready   (Input_Ready),
      .Input_Finish  (Input_Finish),
      .Output_Pixel  (Output_Pixel),
      .Output_Valid  (Output_Valid),
      .Output_Ready  (Output_Ready),
      .Output_Finish (Output_Finish),
      .Watch         (Watch)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, required %0d", name, act, exp);
   endtask

   // Expected 8x8 pixel straight from the upsampling rule on the 4x4 source
   function automatic logic [15:0] model_pixel(input int r, input int c);
      int a;
      int b;
`ifdef UPSAMPLE_BILINEAR_EN
      int a2;
      int b2;
      int s;
      a  = r / 2;
      b  = c / 2;
      a2 = ((r % 2) == 1 && a < 3) ? a + 1 : a;
      b2 = ((c % 2) == 1 && b < 3) ? b + 1 : b;
      s  = int'(src_tile[a*4+b]) + int'(src_tile[a*4+b2])
         + int'(src_tile[a2*4+b]) + int'(src_tile[a2*4+b2]);
      return 16'(s / 4);
`else
      a = r / 2;
      b = c / 2;
      return src_tile[a*4+b];
`endif
   endfunction

   task automatic send_pixel(input logic [15:0] p);
      int n = 0;
      Input_Pixel = p;
      Input_Valid = 1'b1;
      while (!Input_Ready && n < 300) begin
         @(posedge Clock); #1;
         n++;
      end
      if (!Input_Ready) check("in_ready_timeout", int'(Input_Ready), 1);
      @(posedge Clock); #1;
      Input_Valid = 1'b0;
   endtask

   task automatic send_tile(input int base, input int step);
      for (int i = 0; i < 16; i++) src_tile[i] = 16'(base + step * i);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) exp_q.push_back(model_pixel(r, c));
      for (int i = 0; i < 16; i++) send_pixel(src_tile[i]);
   endtask

   task automatic wait_finish(input int target);
      int n = 0;
      while (finish_count < target && n < 3000) begin
         @(negedge Clock); #1;
         n++;
      end
      check("finish_count", finish_count, target);
   endtask

   // Output monitor: every accepted pixel against the model, stalls must hold
   always @(negedge Clock or negedge Input_Reset_n) begin
      if (!Input_Reset_n) begin
         exp_q.delete();
         pix_idx    = 0;
         held_valid = 1'b0;
      end else begin
         if (Output_Valid) begin
            check("valid_finish_exclusive", int'(Output_Finish), 0);
            if (held_valid) check("stall_hold", int'(Output_Pixel), int'(held_pix));
            if (Output_Ready) begin
               held_valid = 1'b0;
               if (exp_q.size() == 0) begin
                  check("unexpected_output", int'(Output_Valid), 0);
               end else begin
                  check($sformatf("pix%0d", pix_idx), int'(Output_Pixel), int'(exp_q.pop_front()));
                  got.push_back(Output_Pixel);
                  pix_idx = (pix_idx + 1) % 64;
                  hs_total++;
               end
            end else begin
               held_valid = 1'b1;
               held_pix   = Output_Pixel;
            end
         end
         if (Output_Finish) finish_count++;
      end
   end

   initial begin
      Output_Ready = 1'b1;
      forever begin
         @(posedge Clock); #1;
         Output_Ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      int hs_before;
      int fc_before;
      int n;

      // Reset values
      #12;
      check("rst_out_valid", int'(Output_Valid), 0);
      check("rst_out_finish", int'(Output_Finish), 0);
      check("rst_watch", int'(Watch), 0);
      check("rst_out_pixel", int'(Output_Pixel), 0);
      check("rst_in_ready", int'(Input_Ready), 1);
      #10 Input_Reset_n = 1'b1;
      @(posedge Clock); #1;

      // Replication pattern 16*i with latency check
      send_tile(0, 16);
      check("lat_valid_before_xfer", int'(Output_Valid), 0);
      check("lat_ready_when_full", int'(Input_Ready), 0);
      @(posedge Clock); #1;
      check("lat_valid_after_xfer", int'(Output_Valid), 1);
      check("lat_ready_after_xfer", int'(Input_Ready), 1);
      wait_finish(1);
      repeat (2) @(negedge Clock);
      check("watch_tile1", int'(Watch), 1);
      check("hs_tile1", hs_total, 64);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("lit_row0_c%0d", i), int'(got[i]), lit_row0[i]);
         check($sformatf("lit_row1_c%0d", i), int'(got[8+i]), lit_row1[i]);
         check($sformatf("lit_row7_c%0d", i), int'(got[56+i]), lit_row7[i]);
      end

      // Backpressure
      hs_before = hs_total;
      bp_mode   = 1'b1;
      send_tile(7, 3);
      wait_finish(2);
      bp_mode = 1'b0;
      repeat (2) @(negedge Clock);
      check("hs_backpressure", hs_total - hs_before, 64);
      check("watch_tile2", int'(Watch), 2);

      // Double buffering
      @(posedge Clock); #1;
      send_tile(50, 1);
      send_tile(100, 1);
      check("dbuf_ready_low_full", int'(Input_Ready), 0);
      wait_finish(3);
      check("dbuf_finish_valid", int'(Output_Valid), 0);
      @(negedge Clock); #1;
      check("dbuf_idle_valid", int'(Output_Valid), 0);
      check("dbuf_idle_ready", int'(Input_Ready), 0);
      check("dbuf_idle_watch", int'(Watch), 3);
      @(negedge Clock); #1;
      check("dbuf_emit_valid", int'(Output_Valid), 1);
      check("dbuf_emit_ready", int'(Input_Ready), 1);
      wait_finish(4);
      repeat (2) @(negedge Clock);
      check("watch_dbuf", int'(Watch), 4);

      // Abort a partial tile, then a tile of 5s
      @(posedge Clock); #1;
      for (int i = 0; i < 7; i++) send_pixel(16'd9);
      Input_Pixel  = 16'd77;
      Input_Valid  = 1'b1;
      Input_Finish = 1'b1;
      @(posedge Clock); #1;
      Input_Valid  = 1'b0;
      Input_Finish = 1'b0;
      send_tile(5, 0);
      wait_finish(5);
      repeat (4) @(negedge Clock);
      check("abort_single_finish", finish_count, 5);
      check("watch_abort", int'(Watch), 5);

      // Asynchronous reset during output pixel 20
      @(posedge Clock); #1;
      send_tile(1000, 1);
      n = 0;
      while (pix_idx < 20 && n < 500) begin
         @(posedge Clock);
         n++;
      end
      check("reach_pix20", pix_idx, 20);
      #3 Input_Reset_n = 1'b0;
      #1;
      fc_before = finish_count;
      check("mid_rst_valid", int'(Output_Valid), 0);
      check("mid_rst_finish", int'(Output_Finish), 0);
      check("mid_rst_watch", int'(Watch), 0);
      check("mid_rst_pixel", int'(Output_Pixel), 0);
      check("mid_rst_ready", int'(Input_Ready), 1);
      repeat (2) @(posedge Clock);
      #2 Input_Reset_n = 1'b1;
      repeat (3) @(negedge Clock);
      check("no_finish_on_reset", finish_count, fc_before);
      @(posedge Clock); #1;
      send_tile(1, 2);
      wait_finish(fc_before + 1);
      repeat (2) @(negedge Clock);
      check("watch_after_reset", int'(Watch), 1);
      check("exp_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

`default_nettype wire
